sseg_scan_display: RTL

- Multi-digit successor to the single-digit keypad-to-seven-segment decoder.
- Captures one-hot 4x4 keypad presses into an NUM_DIGITS-deep shift buffer (newest digit rightmost).
- Time-multiplexes the buffer onto one shared active-low segment bus with active-low digit enables.
- Sits between the keypad scanner and the board's common-anode display pins.

---
 rtl/sseg_pkg.sv | 67 ++++++
 rtl/sseg_debounce.sv | 51 +++++
 rtl/sseg_scan_display.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and decode helpers for the multiplexed seven-segment display.
// Latency: n/a (pure functions). Backpressure: n/a.
// Contents: SSEG_BLANK, key_hex_t, key_to_hex (one-hot keypad -> hex), hex_to_seg (hex -> active-low segments).
package sseg_pkg;

  // All segments and the decimal point off on a common-anode display.
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } key_hex_t;

  // Only an exact one-hot pattern decodes; zero or multi-bit input yields vld=0.
  function automatic key_hex_t key_to_hex(input logic [15:0] k);
    key_hex_t r;
    r.vld = 1'b1;
    r.val = 4'h0;
    case (k)
      16'h0001: r.val = 4'h1;
      16'h0002: r.val = 4'h2;
      16'h0004: r.val = 4'h3;
      16'h0008: r.val = 4'hA;
      16'h0010: r.val = 4'h4;
      16'h0020: r.val = 4'h5;
      16'h0040: r.val = 4'h6;
      16'h0080: r.val = 4'hB;
      16'h0100: r.val = 4'h7;
      16'h0200: r.val = 4'h8;
      16'h0400: r.val = 4'h9;
      16'h0800: r.val = 4'hC;
      16'h1000: r.val = 4'hD;
      16'h2000: r.val = 4'h0;
      16'h4000: r.val = 4'hE;
      16'h8000: r.val = 4'hF;
      default:  r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] seg;
    seg = SSEG_BLANK;
    case (h)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SSEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_debounce.sv
// Generic WIDTH-bit stability filter: output follows input once it has held one value for CYCLES cycles.
// Latency: CYCLES edges after the input settles. Backpressure: none (free-running filter).
// Ports: clk_i, rst_ni (async active-low), in_i [WIDTH] raw value, out_o [WIDTH] filtered value.
module sseg_debounce #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_d is the number of consecutive cycles, including this one, that in_i
  // has held its current value; it saturates so a held key never re-triggers.
  always_comb begin
    samp_d = in_i;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (in_i != samp_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_MAX) begin
      out_d = in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/sseg_scan_display.sv
// Keypad-to-multi-digit display: captures one-hot key presses into a shift buffer and scans it onto a shared segment bus.
// Latency: accept lands 2 edges after keyin goes one-hot (DEBOUNCE_CYCLES+2 with SSEG_DEBOUNCE_EN); display follows 1 edge later.
// Backpressure: none; presses are never stalled, the oldest digit is dropped when full. Optional macro: SSEG_DEBOUNCE_EN.
// Ports: CLK, RST_N (async active-low), keyin[16] one-hot keypad, clr sync buffer clear,
//        sseg[8] active-low segments, anode[NUM_DIGITS] active-low enables, key_strobe, key_value[4], digit_count[4].
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_DIV     = 16000,
  parameter int DEBOUNCE_CYCLES = 160000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [15:0]           keyin,
  input  logic                  clr,
  output logic [7:0]            sseg,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  key_strobe,
  output logic [3:0]            key_value,
  output logic [3:0]            digit_count
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       CNT_MAX  = 4'(NUM_DIGITS);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("sseg_scan_display: parameter out of legal range");
  end

  // ---------------- input path ----------------
  logic [15:0] key_q, key_d, key_prev_q;
  key_hex_t    key_hex;
  logic        accept;

`ifdef SSEG_DEBOUNCE_EN
  sseg_debounce #(
    .WIDTH  (16),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .in_i   (key_q),
    .out_o  (key_d)
  );
`else
  assign key_d = key_q;
`endif

  // A press counts only on a rising edge out of the all-released state, so
  // holding a key or rolling straight onto another key never re-accepts.
  assign key_hex = key_to_hex(key_d);
  assign accept  = key_hex.vld && (key_prev_q == '0);

  // ---------------- digit buffer ----------------
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic [3:0]                 count_q, count_d;
  logic                       strobe_q, strobe_d;
  logic [3:0]                 kval_q, kval_d;

  always_comb begin
    digit_d  = digit_q;
    valid_d  = valid_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    kval_d   = kval_q;
    if (clr) begin
      // Clear wins over a coincident accept; the key is simply lost.
      valid_d = '0;
      count_d = 4'd0;
    end else if (accept) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        digit_d[i] = digit_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      digit_d[0] = key_hex.val;
      valid_d[0] = 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 4'd1;
      end
      strobe_d = 1'b1;
      kval_d   = key_hex.val;
    end
  end

  // ---------------- scan ----------------
  logic [REF_W-1:0]      refresh_q, refresh_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  always_comb begin
    refresh_d = refresh_q + REF_W'(1);
    idx_d     = idx_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // Registered from the current index and buffer so segments and enable
    // always switch together and a buffer update shows on the next edge.
    sseg_d    = valid_q[idx_q] ? hex_to_seg(digit_q[idx_q]) : SSEG_BLANK;
    sseg_d[7] = 1'b1;
    anode_d   = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_q      <= '0;
      key_prev_q <= '0;
      digit_q    <= '0;
      valid_q    <= '0;
      count_q    <= 4'd0;
      strobe_q   <= 1'b0;
      kval_q     <= 4'd0;
      refresh_q  <= '0;
      idx_q      <= '0;
      sseg_q     <= SSEG_BLANK;
      anode_q    <= '1;
    end else begin
      key_q      <= keyin;
      key_prev_q <= key_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      strobe_q   <= strobe_d;
      kval_q     <= kval_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      sseg_q     <= sseg_d;
      anode_q    <= anode_d;
    end
  end

  assign sseg        = sseg_q;
  assign anode       = anode_q;
  assign key_strobe  = strobe_q;
  assign key_value   = kval_q;
  assign digit_count = count_q;

endmodule
